// File: rtl/seq_divider4b_pkg.sv
// seq_divider4b_pkg: shared FSM state type and step-counter sizing for the sequential divider.
package seq_divider4b_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider4b_addsub_nb.sv
// addsub_nb: N-bit ripple add/subtract built from full-adder cells; sub_i=1 gives a - b.
module addsub_nb #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o
);
    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b_i ^ {N{sub_i}};
    assign c[0] = sub_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
        if (i < N - 1) begin : g_c
            assign c[i+1] = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
        end
    end

endmodule

// File: rtl/seq_divider4b.sv
// seq_divider4b: restoring divider, one quotient bit per clock behind a start/done handshake.
module seq_divider4b
    import seq_divider4b_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             dz_q, dz, load;
    logic [WIDTH:0]   r_sh, trial;

    assign r_sh = {r_q, q_q[WIDTH-1]};

    addsub_nb #(.N(WIDTH + 1)) u_sub (
        .a_i   (r_sh),
        .b_i   ({1'b0, dvs_q}),
        .sub_i (1'b1),
        .sum_o (trial)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        case (state_q)
            IDLE: if (start) begin
                dvs_d   = divisor;
                q_d     = dividend;
                r_d     = '0;
                cnt_d   = '0;
                state_d = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                // R' < 2*divisor, so a non-negative trial always fits back in WIDTH bits
                r_d     = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load = (state_d == DONE) && (state_q != DONE);
    assign dz   = (dvs_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            if (load) begin
                quo_q <= dz ? '1 : q_d;
                rem_q <= dz ? q_d : r_d;
                dz_q  <= dz;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider4b.sv
// tb_seq_divider4b: directed and randomized checks of seq_divider4b against an arithmetic model.
module tb_seq_divider4b;
    localparam int W = 4;

    logic         clk, rst, start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    seq_divider4b #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_results(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int eq, er;
        eq = (b == 0) ? (1 << W) - 1 : a / b;
        er = (b == 0) ? a : a % b;
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_by_zero, b == 0);
        if (b != 0) begin
            chk({tag, "_inv"}, int'(quotient) * int'(b) + int'(remainder), a);
            chk({tag, "_rlt"}, remainder < b, 1);
        end
    endtask

    // Issues one division and checks latency, busy, the done pulse and the results.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        seen  = 0;
        while (!seen && lat < 20) begin
            if (done) seen = 1;
            else begin
                chk({tag, "_busy_run"}, busy, 1);
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, lat, (b == 0) ? 1 : W + 1);
        chk({tag, "_busy_done"}, busy, 1);
        chk_results(tag, a, b);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        chk_results({tag, "_hold"}, a, b);
    endtask

    initial begin
        int n_done, gap;
        logic [W-1:0] gq, gr, ba, bb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);

        run_div("d13_3", 4'd13, 4'd3);
        run_div("d15_1", 4'd15, 4'd1);
        run_div("d5_7", 4'd5, 4'd7);
        run_div("d15_15", 4'd15, 4'd15);
        run_div("d0_9", 4'd0, 4'd9);

        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                run_div("exh", W'(a), W'(b));

        run_div("d9_0", 4'd9, 4'd0);
        run_div("d8_2", 4'd8, 4'd2);

        // start pulse during RUN must be ignored
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'd7;
        divisor  = 4'd5;
        n_done   = 0;
        gq       = '0;
        gr       = '0;
        repeat (14) begin
            if (done) begin
                n_done++;
                gq = quotient;
                gr = remainder;
            end
            @(negedge clk);
        end
        chk("ign_ndone", n_done, 1);
        chk("ign_q", gq, 3);
        chk("ign_r", gr, 2);

        // reset in the middle of a division
        @(negedge clk);
        dividend = 4'd11;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_q", quotient, 0);
        chk("mid_r", remainder, 0);
        chk("mid_dz", div_by_zero, 0);
        n_done = 0;
        repeat (10) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("mid_nodone", n_done, 0);
        run_div("d11_2", 4'd11, 4'd2);

        // back-to-back with start held high, random nonzero divisors
        @(negedge clk);
        ba       = W'($urandom_range(0, 15));
        bb       = W'($urandom_range(1, 15));
        dividend = ba;
        divisor  = bb;
        start    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done && gap < 20);
            chk("b2b_done", done, 1);
            if (k > 0) chk("b2b_gap", gap, W + 2);
            chk_results("b2b", ba, bb);
            ba       = W'($urandom_range(0, 15));
            bb       = W'($urandom_range(1, 15));
            dividend = ba;
            divisor  = bb;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // random single divisions, zero divisor included
        for (int k = 0; k < 20; k++)
            run_div("rnd", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
